// File: rtl/regfile_sb_bypass_if.sv
// Bus bundle for the GPR file: read ports, write-back ports, issue port and busy count.
// The master drives addresses/writes/issue; the slave (register file) returns data and status.
interface regfile_sb_bypass_if #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic [ADDR_W:0]       busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
    output rd_data, rd_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_sb_bypass.sv
// Multi-port GPR file with same-cycle write->read bypass and a per-register busy scoreboard.
// x0 is hardwired to zero and never busy; rd_data/rd_busy are forced to zero while rst is low.
module regfile_sb_bypass #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_sb_bypass_if.slave   bus
);
  localparam int ADDR_W = $clog2(NREGS);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_busy;
  logic [ADDR_W:0]   r_busy_cnt;

  logic [NREGS-1:0]      w_clr;
  logic [NREGS-1:0]      w_set;
  logic [NREGS-1:0]      w_busy_nxt;
  logic [ADDR_W-1:0]     w_rd_a;
  logic [DATA_W-1:0]     w_rd_d;
  logic                  w_rd_hit;
  logic                  w_rd_ok;
  logic                  w_wr_match;
  logic [NRD*DATA_W-1:0] w_rd_data;
  logic [NRD-1:0]        w_rd_busy;

  function automatic logic [ADDR_W:0] count_ones(input logic [NREGS-1:0] v);
    logic [ADDR_W:0] c;
    c = {(ADDR_W+1){1'b0}};
    for (int k = 0; k < NREGS; k++) begin
      c = c + {{ADDR_W{1'b0}}, v[k]};
    end
    return c;
  endfunction

  // Next busy vector: write-back clears, issue sets (issue wins a collision), x0 never busy
  always_comb begin
    w_clr = {NREGS{1'b0}};
    w_set = {NREGS{1'b0}};
    for (int i = 0; i < NWR; i++) begin
      w_clr[bus.wr_addr[i*ADDR_W +: ADDR_W]] = w_clr[bus.wr_addr[i*ADDR_W +: ADDR_W]] | bus.wr_en[i];
    end
    w_set[bus.iss_addr] = bus.iss_en;
    w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~{{(NREGS-1){1'b0}}, 1'b1};
  end

  // Register storage; later write ports override earlier ones on an address clash
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NWR; i++) begin
        if (bus.wr_en[i] && (bus.wr_addr[i*ADDR_W +: ADDR_W] != {ADDR_W{1'b0}})) begin
          r_regs[bus.wr_addr[i*ADDR_W +: ADDR_W]] <= bus.wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Scoreboard bits and their registered population count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy     <= {NREGS{1'b0}};
      r_busy_cnt <= {(ADDR_W+1){1'b0}};
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= count_ones(w_busy_nxt);
    end
  end

  // Read ports: stored value, overridden by a same-cycle write (highest port last)
  always_comb begin
    w_rd_data  = {(NRD*DATA_W){1'b0}};
    w_rd_busy  = {NRD{1'b0}};
    w_rd_a     = {ADDR_W{1'b0}};
    w_rd_d     = {DATA_W{1'b0}};
    w_rd_hit   = 1'b0;
    w_rd_ok    = 1'b0;
    w_wr_match = 1'b0;
    for (int j = 0; j < NRD; j++) begin
      w_rd_a   = bus.rd_addr[j*ADDR_W +: ADDR_W];
      w_rd_d   = r_regs[w_rd_a];
      w_rd_hit = 1'b0;
      for (int i = 0; i < NWR; i++) begin
        w_wr_match = bus.wr_en[i] & (bus.wr_addr[i*ADDR_W +: ADDR_W] == w_rd_a);
        w_rd_d     = w_wr_match ? bus.wr_data[i*DATA_W +: DATA_W] : w_rd_d;
        w_rd_hit   = w_rd_hit | w_wr_match;
      end
      w_rd_ok = rst & (w_rd_a != {ADDR_W{1'b0}});
      w_rd_data[j*DATA_W +: DATA_W] = w_rd_ok ? w_rd_d : {DATA_W{1'b0}};
      w_rd_busy[j] = w_rd_ok & r_busy[w_rd_a] & ~w_rd_hit;
    end
  end

  assign bus.rd_data  = w_rd_data;
  assign bus.rd_busy  = w_rd_busy;
  assign bus.busy_cnt = r_busy_cnt;
endmodule
